// File: rtl/costas_pi_loop_filter_if.sv
// rtl/costas_pi_loop_filter_if.sv - phase-error in / NCO word out bundle for the Costas PI loop filter
interface costas_pi_loop_filter_if #(
   parameter int DIN_W  = 28,
   parameter int DOUT_W = 32
);
   logic                     ce;
   logic signed [DIN_W-1:0]  din;
   logic                     freeze;
   logic [DOUT_W-1:0]        dout;
   logic                     dout_valid;
   logic                     int_sat;
   logic                     locked;

   modport master (
      output ce, din, freeze,
      input  dout, dout_valid, int_sat, locked
   );

   modport slave (
      input  ce, din, freeze,
      output dout, dout_valid, int_sat, locked
   );
endinterface

// File: rtl/costas_pi_loop_filter.sv
// rtl/costas_pi_loop_filter.sv - decimating saturating PI loop filter feeding the Costas NCO
// Optional lock detector enabled by defining LOOP_FILTER_LOCK_DET_EN.
module costas_pi_loop_filter #(
   parameter int                DIN_W       = 28,
   parameter int                DOUT_W      = 32,
   parameter int                ACC_W       = 40,
   parameter int                PERIOD      = 14,
   parameter int                KI_SHIFT    = 13,
   parameter int                KP_SHIFT    = 6,
   parameter logic [DOUT_W-1:0] START_FREQ  = 32'h2000_0000,
   parameter int                LOCK_THRESH = 1024,
   parameter int                LOCK_CNT    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   costas_pi_loop_filter_if.slave bus
);
   localparam int CNT_W = $clog2(PERIOD);
   localparam int Y_W   = ((ACC_W > DOUT_W) ? ACC_W : DOUT_W) + 2;

   logic [CNT_W-1:0]         r_cnt;
   logic signed [DIN_W-1:0]  r_e;
   logic                     r_s0_vld;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [DIN_W-1:0]  r_p;
   logic                     r_s1_vld;
   logic                     r_int_sat;
   logic [DOUT_W-1:0]        r_dout;
   logic                     r_dout_vld;

   logic                     w_last;
   logic                     w_capture;
   logic signed [DIN_W-1:0]  w_ki;
   logic signed [DIN_W-1:0]  w_kp;
   logic [ACC_W:0]           w_sum;
   logic                     w_acc_clip;
   logic [ACC_W-1:0]         w_acc_sat;
   logic [Y_W-1:0]           w_y;
   logic [DOUT_W-1:0]        w_y_sat;

   assign w_last    = (r_cnt == CNT_W'(PERIOD - 1));
   assign w_capture = bus.ce && w_last;
   assign w_ki      = r_e >>> KI_SHIFT;
   assign w_kp      = r_e >>> KP_SHIFT;

   // One guard bit: overflow shows up as the two top bits disagreeing.
   always_comb begin
      w_sum      = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-DIN_W){w_ki[DIN_W-1]}}, w_ki};
      w_acc_clip = (w_sum[ACC_W] != w_sum[ACC_W-1]);
      w_acc_sat  = w_sum[ACC_W-1:0];
      if (w_acc_clip)
         w_acc_sat = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end

   always_comb begin
      w_y = {{(Y_W-DOUT_W){1'b0}}, START_FREQ}
          + {{(Y_W-ACC_W){r_acc[ACC_W-1]}}, r_acc}
          + {{(Y_W-DIN_W){r_p[DIN_W-1]}}, r_p};
      w_y_sat = w_y[DOUT_W-1:0];
      if (w_y[Y_W-1])
         w_y_sat = '0;
      else if (|w_y[Y_W-2:DOUT_W])
         w_y_sat = '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_e        <= '0;
         r_s0_vld   <= 1'b0;
         r_acc      <= '0;
         r_p        <= '0;
         r_s1_vld   <= 1'b0;
         r_int_sat  <= 1'b0;
         r_dout     <= START_FREQ;
         r_dout_vld <= 1'b0;
      end else begin
         if (bus.ce)
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         r_s0_vld <= w_capture;
         if (w_capture)
            r_e <= bus.din;
         r_s1_vld <= r_s0_vld;
         if (r_s0_vld) begin
            r_p <= w_kp;
            if (bus.freeze) begin
               r_int_sat <= 1'b0;
            end else begin
               r_acc     <= w_acc_sat;
               r_int_sat <= w_acc_clip;
            end
         end
         r_dout_vld <= r_s1_vld;
         if (r_s1_vld)
            r_dout <= w_y_sat;
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_dout_vld;
   assign bus.int_sat    = r_int_sat;

`ifdef LOOP_FILTER_LOCK_DET_EN
   localparam int LCK_W = $clog2(LOCK_CNT + 1);

   logic [LCK_W-1:0] r_lock_cnt;
   logic             r_locked;
   logic [DIN_W-1:0] w_abs_e;
   logic             w_in_thresh;

   // Magnitude as unsigned so the most negative error still compares correctly.
   assign w_abs_e     = r_e[DIN_W-1] ? (~r_e + 1'b1) : r_e;
   assign w_in_thresh = ({1'b0, w_abs_e} < (DIN_W+1)'(LOCK_THRESH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
      end else begin
         if (r_s0_vld) begin
            if (!w_in_thresh)
               r_lock_cnt <= '0;
            else if (r_lock_cnt != LCK_W'(LOCK_CNT))
               r_lock_cnt <= r_lock_cnt + 1'b1;
         end
         if (r_s1_vld)
            r_locked <= (r_lock_cnt == LCK_W'(LOCK_CNT));
      end
   end

   assign bus.locked = r_locked;
`else
   logic w_unused_lock;
   assign w_unused_lock = ^{32'(LOCK_THRESH), 32'(LOCK_CNT)};
   assign bus.locked    = 1'b0;
`endif
endmodule

// File: tb/tb_costas_pi_loop_filter.sv
// tb/tb_costas_pi_loop_filter.sv - directed checks of the Costas PI loop filter
module tb_costas_pi_loop_filter;
   localparam int          PER   = 14;
   localparam logic [31:0] START = 32'h2000_0000;
`ifdef LOOP_FILTER_LOCK_DET_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   int          g_lat;
   logic [31:0] g_dout, g_sdout;
   logic        g_sat, g_ssat, g_lock, g_dv_next;

   always #5 clk = ~clk;

   costas_pi_loop_filter_if #(.DIN_W(28), .DOUT_W(32)) mif ();
   costas_pi_loop_filter_if #(.DIN_W(28), .DOUT_W(32)) sif ();

   // Second instance sized so a full-scale error saturates the integrator quickly.
   assign sif.ce     = mif.ce;
   assign sif.freeze = mif.freeze;
   assign sif.din    = 28'sh7FF_FFFF;

   costas_pi_loop_filter u_dut (
      .clk (clk),
      .rst (rst),
      .bus (mif)
   );

   costas_pi_loop_filter #(.DIN_W(28), .ACC_W(28), .KI_SHIFT(0)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mif.ce = 1'b0;
      mif.freeze = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // PERIOD strobes, then wait (bounded) for the resulting dout_valid.
   task automatic do_update(input logic signed [27:0] d, input logic frz);
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         mif.ce = 1'b1;
         mif.din = d;
         mif.freeze = frz;
      end
      @(negedge clk);
      mif.ce = 1'b0;
      g_lat = 0;
      while (!mif.dout_valid && g_lat < 8) begin
         @(negedge clk);
         g_lat++;
      end
      g_dout = mif.dout;
      g_sat  = mif.int_sat;
      g_lock = mif.locked;
      g_sdout = sif.dout;
      g_ssat  = sif.int_sat;
      @(negedge clk);
      g_dv_next = mif.dout_valid;
   endtask

   initial begin
      int nv;
      mif.ce = 1'b0;
      mif.din = '0;
      mif.freeze = 1'b0;

      do_reset();
      chk("rst_dout", mif.dout, START);
      chk("rst_dv", mif.dout_valid, 1'b0);
      chk("rst_locked", mif.locked, 1'b0);
      chk("rst_int_sat", mif.int_sat, 1'b0);
      chk("rst_sat_dout", sif.dout, START);

      for (int u = 0; u < 3; u++) begin
         do_update(28'sd8192, 1'b0);
         chk($sformatf("c8192_lat%0d", u), g_lat, 2);
         chk($sformatf("c8192_pulse%0d", u), g_dv_next, 1'b0);
         chk($sformatf("c8192_dout%0d", u), g_dout, START + 32'd129 + 32'(u));
         chk($sformatf("c8192_int_sat%0d", u), g_sat, 1'b0);
         chk($sformatf("sat_flag%0d", u), g_ssat, (u > 0));
         chk($sformatf("sat_dout%0d", u), g_sdout, 32'h281F_FFFE);
         chk($sformatf("sat_nowrap%0d", u), (g_sdout >= START), 1'b1);
      end

      do_reset();
      do_update(-28'sd1, 1'b0);
      chk("neg1_dout", g_dout, 32'h1FFF_FFFE);
      chk("neg1_int_sat", g_sat, 1'b0);

      do_reset();
      for (int u = 0; u < 3; u++) begin
         do_update(28'sd8192, 1'b1);
         chk($sformatf("frz_dout%0d", u), g_dout, 32'h2000_0080);
         chk($sformatf("frz_int_sat%0d", u), g_sat, 1'b0);
      end
      do_update(28'sd8192, 1'b0);
      chk("unfrz_dout", g_dout, 32'h2000_0081);

      // Capture happens, then reset during S1: no update may emerge.
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         mif.ce = 1'b1;
         mif.din = 28'sd8192;
      end
      @(negedge clk);
      mif.ce = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      nv = 0;
      repeat (4) begin
         @(negedge clk);
         if (mif.dout_valid) nv++;
      end
      chk("midrst_valids", nv, 0);
      chk("midrst_dout", mif.dout, START);

      do_reset();
      for (int u = 0; u < 16; u++) begin
         do_update(28'sd100, 1'b0);
         chk($sformatf("lock_dout%0d", u), g_dout, 32'h2000_0001);
         chk($sformatf("lock%0d", u), g_lock, LOCK_EN && (u == 15));
      end
      do_update(28'sd5000, 1'b0);
      chk("unlock_dout", g_dout, 32'h2000_004E);
      chk("unlock", g_lock, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/costas_pi_loop_filter.md
Name: costas_pi_loop_filter

Overview:
Parametrised proportional-integral loop filter for the Costas carrier-recovery loop. It takes the signed phase-detector error on a decimated strobe grid and produces an NCO frequency control word. Compared with the earlier fixed filter, it adds:
- configurable widths, gains and update period;
- a saturating integrator and saturating output;
- a freeze control and a registered output-valid pulse.

It sits between the phase detector and the NCO frequency input.

Parameters:
DIN_W, 28, width of signed phase-error input
DOUT_W, 32, width of unsigned NCO frequency word output
ACC_W, 40, width of signed integrator (must be >= DIN_W)
PERIOD, 14, number of ce strobes per filter update (>= 2)
KI_SHIFT, 13, integral gain = 2^-KI_SHIFT (arithmetic right shift)
KP_SHIFT, 6, proportional gain = 2^-KP_SHIFT (arithmetic right shift)
START_FREQ, 32'h2000_0000, nominal NCO word added to filter output (DOUT_W bits)
LOCK_THRESH, 1024, |din| threshold for lock detect (optional feature only)
LOCK_CNT, 16, consecutive in-threshold updates required to declare lock (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ce  in  1  sample strobe from phase detector
din  in  DIN_W  signed phase error, valid when ce=1
freeze  in  1  hold integrator (proportional path still active)
dout  out  DOUT_W  NCO frequency word
dout_valid  out  1  one-cycle pulse when dout updates
int_sat  out  1  integrator clamped on last update (sticky until next update)
locked  out  1  lock indication (0 when optional feature compiled out)

Behaviour:
- Reset values:
  - dout=START_FREQ; dout_valid=0; int_sat=0; locked=0.
  - Integrator=0; cnt=0; pipeline valids=0.
- Strobe counter cnt:
  - Range 0..PERIOD-1; advances only on ce; wraps PERIOD-1 -> 0.
- Capture:
  - When ce=1 and cnt==PERIOD-1, din is registered into e (stage S0 valid).
  - All other ce samples are ignored (decimation).
- Stage S1 (cycle after capture):
  - acc_next = acc + sign_extend(e >>> KI_SHIFT), computed at ACC_W+1 bits.
  - Result clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; int_sat = clamp occurred.
  - If freeze=1 during S1: acc unchanged, int_sat=0.
  - The proportional term p = e >>> KP_SHIFT is registered alongside.
- Stage S2 (cycle after S1):
  - y = START_FREQ + acc + p, computed signed at ACC_W+2 bits.
  - y clamped to [0, 2^DOUT_W-1] and registered to dout.
  - dout_valid=1 for exactly this cycle.
- Latency: dout_valid asserts 2 clk cycles after the capturing ce edge.
- Timing: new ce strobes during S1/S2 are counted normally. Since PERIOD >= 2, pipeline stages never collide.
- Shifts: all shifts are arithmetic, i.e. floor rounding (-1 >>> n = -1).
- dout holds its value between updates.
- Reset mid-pipeline: pending S0/S1 results are discarded; no dout_valid is issued after rst.
- freeze toggled between updates: takes effect only at the S1 cycle.

Optional Feature:
Macro LOOP_FILTER_LOCK_DET_EN.
- Defined:
  - A lock counter evaluates each S1 update.
  - If |e| < LOCK_THRESH, the counter increments, saturating at LOCK_CNT; otherwise it clears to 0.
  - locked=1 while counter==LOCK_CNT, registered on the S2 cycle.
  - Reset clears counter and locked.
- Not defined:
  - locked is tied to 0 and no lock logic is synthesised.

Test Plan:
- Reset: assert rst 3 cycles -> dout=32'h2000_0000, dout_valid=0, locked=0, int_sat=0.
- Constant din=8192, ce every cycle, defaults:
  - first dout_valid 2 cycles after the 14th ce;
  - dout=32'h2000_0081 (acc=1, p=128);
  - second update dout=32'h2000_0082.
- din=-1 on the capturing strobe, acc=0 -> dout=32'h1FFF_FFFE (floor rounding, both paths -1).
- freeze=1 with din=8192 over 3 updates -> each dout=32'h2000_0080; integrator stays 0.
- Saturation (ACC_W=DIN_W=28, KI_SHIFT=0), din=2^27-1 sustained -> int_sat=1 from the second update onward. dout never wraps below START_FREQ.
- With LOOP_FILTER_LOCK_DET_EN, din=100 for 16 updates:
  - locked rises with the 16th dout_valid;
  - one update with din=5000 -> locked=0 on the next dout_valid.
